// File: rtl/cpu_axi_pkg.sv
`default_nettype none
// ============================================================================
// cpu_axi_pkg
// Shared types and constants for the cache-to-AXI read/write arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package cpu_axi_pkg;

  // Read-side FSM states
  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  // Word-sized INCR bursts are the only kind the caches issue
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Default transaction IDs per requester
  localparam int unsigned DEF_I_ID = 0;
  localparam int unsigned DEF_D_ID = 1;

  // Grant encoding: 0 = I-cache, 1 = D-cache
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

endpackage
`default_nettype wire

// File: rtl/cache_axi_arbiter_arb_grant.sv
`default_nettype none
// ============================================================================
// arb_grant
// Chooses between the I-cache and D-cache read requests. With
// ARB_ROUND_ROBIN_EN defined, a 1-bit pointer remembers the last requester
// served and a tie goes to the other one; otherwise the D-cache wins ties.
// Revision: 1.0 - initial release
// ============================================================================
module arb_grant
  import cpu_axi_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic load_i,
  output logic gnt_o
);

`ifdef ARB_ROUND_ROBIN_EN
  logic ptr_q;
  logic ptr_d;

  // Pointer follows the grant whenever the FSM registers one
  assign ptr_d = load_i ? gnt_o : ptr_q;

  // Last-served pointer; reset value says the I-cache was served last
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= GNT_I;
    else     ptr_q <= ptr_d;
  end

  // Tie goes to the requester not served last
  always_comb begin
    gnt_o = GNT_I;
    if (i_req_i && d_req_i) gnt_o = ~ptr_q;
    else if (d_req_i)       gnt_o = GNT_D;
  end
`else
  // Fixed priority keeps no state, so these inputs have no effect here
  logic unused_inputs;
  assign unused_inputs = clk ^ rst ^ load_i ^ i_req_i;

  // D-cache always wins; with only the I-cache requesting, I is chosen
  always_comb begin
    gnt_o = GNT_I;
    if (d_req_i) gnt_o = GNT_D;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/cache_axi_arbiter.sv
`default_nettype none
// ============================================================================
// cache_axi_arbiter
// Shares one AXI master port between the I-cache and D-cache. Reads are
// arbitrated one burst at a time and tagged with the requester ID; the
// D-cache write channels pass straight through to the bus.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin tie breaking).
// Revision: 1.0 - initial release
// ============================================================================
module cache_axi_arbiter
  import cpu_axi_pkg::*;
#(
  parameter int unsigned ID_WIDTH = 4,
  parameter int unsigned I_ID     = DEF_I_ID,
  parameter int unsigned D_ID     = DEF_D_ID
) (
  input  logic                clk,
  input  logic                rst,
  // I-cache read
  input  logic [31:0]         i_araddr,
  input  logic [7:0]          i_arlen,
  input  logic                i_arvalid,
  output logic                i_arready,
  output logic [31:0]         i_rdata,
  output logic                i_rlast,
  output logic                i_rvalid,
  input  logic                i_rready,
  // D-cache read
  input  logic [31:0]         d_araddr,
  input  logic [7:0]          d_arlen,
  input  logic                d_arvalid,
  output logic                d_arready,
  output logic [31:0]         d_rdata,
  output logic                d_rlast,
  output logic                d_rvalid,
  input  logic                d_rready,
  // D-cache write
  input  logic [31:0]         d_awaddr,
  input  logic [7:0]          d_awlen,
  input  logic [2:0]          d_awsize,
  input  logic                d_awvalid,
  output logic                d_awready,
  input  logic [31:0]         d_wdata,
  input  logic [3:0]          d_wstrb,
  input  logic                d_wlast,
  input  logic                d_wvalid,
  output logic                d_wready,
  output logic                d_bvalid,
  input  logic                d_bready,
  // AXI read address / data
  output logic [ID_WIDTH-1:0] arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_WIDTH-1:0] rid,
  input  logic [31:0]         rdata,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  // AXI write channels
  output logic [ID_WIDTH-1:0] awid,
  output logic [31:0]         awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_WIDTH-1:0] bid,
  input  logic                bvalid,
  output logic                bready
);

  localparam logic [ID_WIDTH-1:0] I_ID_W = ID_WIDTH'(I_ID);
  localparam logic [ID_WIDTH-1:0] D_ID_W = ID_WIDTH'(D_ID);

  rd_state_e state_q, state_d;
  logic      gnt_q, gnt_d;
  logic      w_gnt;
  logic      w_load;

  // Only one read is ever outstanding, so returned IDs carry no information
  logic unused_ids;
  assign unused_ids = ^{rid, bid};

  arb_grant u_arb_grant (
    .clk     (clk),
    .rst     (rst),
    .i_req_i (i_arvalid),
    .d_req_i (d_arvalid),
    .load_i  (w_load),
    .gnt_o   (w_gnt)
  );

  // Read FSM state and grant registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= R_IDLE;
      gnt_q   <= GNT_I;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
    end
  end

  // Next-state logic and handshake routing to the granted requester
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    w_load    = 1'b0;
    arvalid   = 1'b0;
    i_arready = 1'b0;
    d_arready = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    i_rlast   = 1'b0;
    d_rlast   = 1'b0;
    rready    = 1'b0;
    case (state_q)
      R_IDLE: begin
        if (i_arvalid || d_arvalid) begin
          w_load  = 1'b1;
          gnt_d   = w_gnt;
          state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        // A requester dropping arvalid here just stalls; no re-arbitration
        arvalid   = (gnt_q == GNT_D) ? d_arvalid : i_arvalid;
        i_arready = (gnt_q == GNT_I) && arready;
        d_arready = (gnt_q == GNT_D) && arready;
        if (arvalid && arready) state_d = R_DATA;
      end
      R_DATA: begin
        i_rvalid = (gnt_q == GNT_I) && rvalid;
        d_rvalid = (gnt_q == GNT_D) && rvalid;
        i_rlast  = (gnt_q == GNT_I) && rlast;
        d_rlast  = (gnt_q == GNT_D) && rlast;
        rready   = (gnt_q == GNT_D) ? d_rready : i_rready;
        if (rvalid && rready && rlast) state_d = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
  end

  // Read address payload from the granted requester; data broadcast to both
  assign arid    = (gnt_q == GNT_D) ? D_ID_W : I_ID_W;
  assign araddr  = (gnt_q == GNT_D) ? d_araddr : i_araddr;
  assign arlen   = (gnt_q == GNT_D) ? d_arlen : i_arlen;
  assign arsize  = AXI_SIZE_WORD;
  assign arburst = AXI_BURST_INCR;
  assign i_rdata = rdata;
  assign d_rdata = rdata;

  // Write channels are a straight pass-through, independent of the read FSM
  assign awid      = D_ID_W;
  assign awaddr    = d_awaddr;
  assign awlen     = d_awlen;
  assign awsize    = d_awsize;
  assign awburst   = AXI_BURST_INCR;
  assign awvalid   = d_awvalid;
  assign d_awready = awready;
  assign wdata     = d_wdata;
  assign wstrb     = d_wstrb;
  assign wlast     = d_wlast;
  assign wvalid    = d_wvalid;
  assign d_wready  = wready;
  assign d_bvalid  = bvalid;
  assign bready    = d_bready;

endmodule
`default_nettype wire
